fwd_hazard_unit: RTL and testbench

- Parametrised successor to the two-source ALU forwarding unit.
- Tracks in-flight register writers across a configurable number of post-EX stages, for any number of read ports.
- Generates a registered per-port forwarding select for the instruction entering EX, plus a combinational ID-stage stall for load-use / multi-cycle producer hazards.
- Sits beside the ID/EX pipeline register; the datapath forwarding muxes are widened to DEPTH+1 inputs.

---
 rtl/fwd_hazard_unit_pkg.sv | 21 ++
 rtl/fwd_port_match.sv | 40 ++++
 rtl/fwd_hazard_unit.sv | 100 ++++++++++
 tb/tb_fwd_hazard_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types and helpers for the parametrised forwarding / hazard unit.
package fwd_hazard_unit_pkg;

  localparam int unsigned FWD_REGFILE = 0;
  // Slots store register numbers at this fixed width; AW must not exceed it.
  localparam int unsigned MAX_AW = 8;

  typedef struct packed {
    logic              v;
    logic [MAX_AW-1:0] wn;
    logic              regw;
    logic              load;
  } slot_t;

  // A producer sitting at next-cycle position q can supply its result from there.
  function automatic logic fwd_ready(input logic is_load, input int unsigned q,
                                     input int unsigned load_lat);
    return !is_load || (q + 1 >= load_lat);
  endfunction

endpackage

// File: rtl/fwd_port_match.sv
// Youngest-writer search and readiness check for a single source read port.
module fwd_port_match
  import fwd_hazard_unit_pkg::*;
#(
  parameter int unsigned AW       = 5,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned LOAD_LAT = 2,
  parameter int unsigned SW       = 2
) (
  input  logic [AW-1:0] rs_i,
  input  logic          used_i,
  input  slot_t [DEPTH:0] cand_i,
  output logic          hit_o,
  output logic [SW-1:0] q_o,
  output logic          hazard_o
);

  logic found;
  logic ready;

  // Oldest first so the youngest match is the last one written.
  always_comb begin
    found = 1'b0;
    q_o   = '0;
    ready = 1'b1;
    for (int i = DEPTH; i >= 0; i--) begin
      if (used_i && (rs_i != '0) && cand_i[i].v && cand_i[i].regw &&
          (cand_i[i].wn == MAX_AW'(rs_i))) begin
        found = 1'b1;
        q_o   = SW'(i);
        ready = fwd_ready(cand_i[i].load, unsigned'(i), LOAD_LAT);
      end
    end
  end

  // Position DEPTH has reached the regfile: no forward, no hazard.
  assign hit_o    = found && (q_o != SW'(DEPTH));
  assign hazard_o = hit_o && !ready;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Tracks in-flight writers, produces registered per-port forwarding selects and the ID stall.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int unsigned AW       = 5,
  parameter int unsigned NRP      = 2,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned LOAD_LAT = 2,
  parameter int unsigned SW       = 2,
  parameter int unsigned CW       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [NRP*AW-1:0] id_rs,
  input  logic [NRP-1:0]    id_rs_used,
  input  logic [AW-1:0]     id_wn,
  input  logic              id_regw,
  input  logic              id_is_load,
  input  logic              flush,
  output logic              stall,
  output logic [NRP*SW-1:0] fwd_sel,
  output logic [AW-1:0]     ex_wn,
  output logic [CW-1:0]     stall_cnt
);

  slot_t             ex_q, ex_d;
  slot_t [DEPTH-1:0] ent_q;
  slot_t [DEPTH:0]   cand;
  logic [NRP-1:0]    hit, hazard;
  logic [SW-1:0]     q [NRP];
  logic [NRP*SW-1:0] sel_d, sel_q;
  logic [CW-1:0]     cnt_d, cnt_q;
  logic              issue;

  // Candidates indexed by where each writer will sit next cycle.
  always_comb begin
    cand    = '0;
    cand[0] = ex_q;
    for (int k = 1; k <= DEPTH; k++) cand[k] = ent_q[k-1];
  end

  for (genvar p = 0; p < NRP; p++) begin : g_port
    fwd_port_match #(
      .AW       (AW),
      .DEPTH    (DEPTH),
      .LOAD_LAT (LOAD_LAT),
      .SW       (SW)
    ) u_match (
      .rs_i     (id_rs[p*AW +: AW]),
      .used_i   (id_rs_used[p]),
      .cand_i   (cand),
      .hit_o    (hit[p]),
      .q_o      (q[p]),
      .hazard_o (hazard[p])
    );
  end

  assign stall = id_valid && !flush && (|hazard);
  assign issue = id_valid && !stall && !flush;

  always_comb begin
    ex_d = '0;
    if (issue) begin
      ex_d.v    = 1'b1;
      ex_d.wn   = MAX_AW'(id_wn);
      ex_d.regw = id_regw;
      ex_d.load = id_is_load;
    end
  end

  always_comb begin
    sel_d = {NRP{SW'(FWD_REGFILE)}};
    for (int p = 0; p < NRP; p++) begin
      if (issue && hit[p] && !hazard[p]) sel_d[p*SW +: SW] = q[p] + SW'(1);
    end
  end

  assign cnt_d = (stall && (cnt_q != '1)) ? cnt_q + CW'(1) : cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_q  <= '0;
      ent_q <= '0;
      sel_q <= '0;
      cnt_q <= '0;
    end else begin
      ex_q     <= ex_d;
      ent_q[0] <= ex_q;
      for (int k = 1; k < DEPTH; k++) ent_q[k] <= ent_q[k-1];
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
    end
  end

  assign fwd_sel   = sel_q;
  assign ex_wn     = ex_q.wn[AW-1:0];
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench: directed vector table, random stimulus against an issue-history model.
module tb_fwd_hazard_unit;

  localparam int AW       = 5;
  localparam int NRP      = 2;
  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 2;
  localparam int SW       = 2;
  localparam int CW       = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [NRP*AW-1:0] id_rs;
  logic [NRP-1:0]    id_rs_used;
  logic [AW-1:0]     id_wn;
  logic              id_regw;
  logic              id_is_load;
  logic              flush;
  logic              stall;
  logic [NRP*SW-1:0] fwd_sel;
  logic [AW-1:0]     ex_wn;
  logic [CW-1:0]     stall_cnt;

  fwd_hazard_unit #(
    .AW       (AW),
    .NRP      (NRP),
    .DEPTH    (DEPTH),
    .LOAD_LAT (LOAD_LAT),
    .SW       (SW),
    .CW       (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rs_used (id_rs_used),
    .id_wn      (id_wn),
    .id_regw    (id_regw),
    .id_is_load (id_is_load),
    .flush      (flush),
    .stall      (stall),
    .fwd_sel    (fwd_sel),
    .ex_wn      (ex_wn),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: hist[i] is the instruction issued i+1 cycles ago (bubbles included).
  typedef struct {
    bit v;
    int wn;
    bit regw;
    bit ld;
  } rec_t;

  rec_t hist[$];
  bit   m_stall;
  int   m_nsel[NRP];
  int   m_sel[NRP];
  int   m_wn;
  int   m_cnt;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    rec_t e;
    e.v = 0; e.wn = 0; e.regw = 0; e.ld = 0;
    hist.delete();
    for (int i = 0; i <= DEPTH; i++) hist.push_back(e);
    m_cnt = 0;
    m_wn  = 0;
    for (int p = 0; p < NRP; p++) m_sel[p] = 0;
  endfunction

  // An instruction issued i+1 cycles ago delivers its result i cycles from now;
  // a load only after LOAD_LAT-1 of those. Age DEPTH or more means the regfile has it.
  function automatic void model_eval();
    bit haz = 0;
    for (int p = 0; p < NRP; p++) begin
      int r;
      r = int'(id_rs[p*AW +: AW]);
      m_nsel[p] = 0;
      if (id_rs_used[p] && r != 0) begin
        for (int i = 0; i < hist.size(); i++) begin
          if (hist[i].v && hist[i].regw && hist[i].wn == r) begin
            if (i < DEPTH) begin
              if (!hist[i].ld || i >= LOAD_LAT - 1) m_nsel[p] = i + 1;
              else haz = 1;
            end
            break;
          end
        end
      end
    end
    m_stall = id_valid && !flush && haz;
  endfunction

  function automatic void model_commit();
    rec_t n;
    bit   issue;
    if (!rst) begin
      model_clear();
      return;
    end
    issue  = id_valid && !m_stall && !flush;
    n.v    = issue;
    n.wn   = issue ? int'(id_wn) : 0;
    n.regw = issue && id_regw;
    n.ld   = issue && id_is_load;
    hist.push_front(n);
    void'(hist.pop_back());
    m_wn = n.wn;
    for (int p = 0; p < NRP; p++) m_sel[p] = issue ? m_nsel[p] : 0;
    if (m_stall && m_cnt < (1 << CW) - 1) m_cnt++;
  endfunction

  // Called just after a rising edge: drive inputs, settle, evaluate the model.
  task automatic drive(input bit r, input bit v, input int rs0, input int rs1,
                       input bit [1:0] used, input int wn, input bit regw, input bit ld,
                       input bit fl);
    logic [AW-1:0] a0, a1;
    a0 = AW'(rs0);
    a1 = AW'(rs1);
    rst        = r;
    id_valid   = v;
    id_rs      = {a1, a0};
    id_rs_used = used;
    id_wn      = AW'(wn);
    id_regw    = regw;
    id_is_load = ld;
    flush      = fl;
    #2;
    model_eval();
  endtask

  task automatic tick();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, " fwd_sel0"}, int'(fwd_sel[0 +: SW]), m_sel[0]);
    check({tag, " fwd_sel1"}, int'(fwd_sel[SW +: SW]), m_sel[1]);
    check({tag, " ex_wn"}, int'(ex_wn), m_wn);
    check({tag, " stall_cnt"}, int'(stall_cnt), m_cnt);
  endtask

  typedef struct {
    bit       r;
    bit       v;
    int       rs0;
    int       rs1;
    bit [1:0] used;
    int       wn;
    bit       regw;
    bit       ld;
    bit       fl;
    bit       e_st;
    int       e_s0;
    int       e_s1;
    int       e_wn;
    int       e_cnt;
  } vec_t;

  vec_t tbl[20];

  initial begin
    // r v rs0 rs1 used wn regw ld fl | stall sel0 sel1 ex_wn cnt (sel/wn/cnt after the edge)
    tbl[0]  = '{0, 0,  0,  0, 2'b00,  0, 0, 0, 0, 0, 0, 0,  0, 0}; // reset
    tbl[1]  = '{1, 1,  1,  2, 2'b11,  3, 1, 0, 0, 0, 0, 0,  3, 0}; // add r3
    tbl[2]  = '{1, 1,  3,  3, 2'b11,  4, 1, 0, 0, 0, 1, 1,  4, 0}; // sub r4,r3,r3
    tbl[3]  = '{1, 1,  1,  0, 2'b01,  5, 1, 1, 0, 0, 0, 0,  5, 0}; // lw r5
    tbl[4]  = '{1, 1,  5,  1, 2'b11,  6, 1, 0, 0, 1, 0, 0,  0, 1}; // add r6,r5,r1 stalls
    tbl[5]  = '{1, 1,  5,  1, 2'b11,  6, 1, 0, 0, 0, 2, 0,  6, 1}; // retry issues
    tbl[6]  = '{1, 1,  0,  0, 2'b00,  7, 1, 0, 0, 0, 0, 0,  7, 1}; // add r7
    tbl[7]  = '{1, 1,  0,  0, 2'b00,  7, 1, 0, 0, 0, 0, 0,  7, 1}; // add r7 again
    tbl[8]  = '{1, 0,  0,  0, 2'b00,  0, 0, 0, 0, 0, 0, 0,  0, 1}; // nop
    tbl[9]  = '{1, 1,  7,  7, 2'b11,  8, 1, 0, 0, 0, 2, 2,  8, 1}; // use r7: younger write
    tbl[10] = '{1, 1,  0,  0, 2'b00,  0, 1, 0, 0, 0, 0, 0,  0, 1}; // write r0
    tbl[11] = '{1, 1,  0,  0, 2'b11,  9, 1, 0, 0, 0, 0, 0,  9, 1}; // use r0
    tbl[12] = '{1, 1,  0,  0, 2'b00, 10, 1, 1, 0, 0, 0, 0, 10, 1}; // lw r10
    tbl[13] = '{1, 1,  1, 10, 2'b01, 11, 1, 0, 0, 0, 0, 0, 11, 1}; // port1 unused
    tbl[14] = '{1, 1,  0,  0, 2'b00, 12, 1, 1, 0, 0, 0, 0, 12, 1}; // lw r12
    tbl[15] = '{1, 1, 12,  0, 2'b01, 13, 1, 0, 1, 0, 0, 0,  0, 1}; // flush over hazard
    tbl[16] = '{1, 1, 12, 12, 2'b11, 13, 1, 0, 0, 0, 2, 2, 13, 1}; // load still in flight
    tbl[17] = '{1, 1,  0,  0, 2'b00, 14, 1, 1, 0, 0, 0, 0, 14, 1}; // lw r14
    tbl[18] = '{0, 1, 14,  0, 2'b01, 15, 1, 0, 0, 1, 0, 0,  0, 0}; // reset mid-stall
    tbl[19] = '{1, 1, 14,  0, 2'b01, 15, 1, 0, 0, 0, 0, 0, 15, 0}; // nothing left to match

    model_clear();
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(tbl[i].r, tbl[i].v, tbl[i].rs0, tbl[i].rs1, tbl[i].used, tbl[i].wn,
            tbl[i].regw, tbl[i].ld, tbl[i].fl);
      check({tag, " stall"}, int'(stall), int'(tbl[i].e_st));
      tick();
      check({tag, " fwd_sel0"}, int'(fwd_sel[0 +: SW]), tbl[i].e_s0);
      check({tag, " fwd_sel1"}, int'(fwd_sel[SW +: SW]), tbl[i].e_s1);
      check({tag, " ex_wn"}, int'(ex_wn), tbl[i].e_wn);
      check({tag, " stall_cnt"}, int'(stall_cnt), tbl[i].e_cnt);
    end

    // Random traffic over a small register set to provoke frequent matches.
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 49) != 0, $urandom_range(0, 7) != 0,
            $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom_range(0, 3)),
            $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) == 0);
      check("rand stall", int'(stall), int'(m_stall));
      tick();
      check_model("rand");
    end

    // A load that reads its own destination stalls every other cycle when held in ID.
    drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    tick();
    for (int n = 0; n < 140; n++) begin
      drive(1, 1, 5, 0, 2'b01, 5, 1, 1, 0);
      check("sat stall", int'(stall), int'(m_stall));
      tick();
      check_model("sat");
    end
    check("sat held at all-ones", int'(stall_cnt), (1 << CW) - 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
